// File: rtl/pio_edge_capture_in.sv
// Avalon-MM parallel input port with synchronizer, edge detection, sticky capture and masked irq.
// Optional macro PIO_EDGE_BIT_CLEAR_EN: per-bit clear of the capture register instead of clear-all.
module pio_edge_capture_in #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q_s;
  logic [WIDTH-1:0] prev_q_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] capture_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] set_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] capture_next_s;
  logic [2:0]       arm_cnt_r;
  logic             armed_s;
  logic             wr_s;
  logic [31:0]      rdata_s;
  logic             unused_wdata_s;

  assign sync_q_s       = sync_r[SYNC_STAGES-1];
  assign armed_s        = (arm_cnt_r == ARM_MAX);
  assign wr_s           = chipselect & ~write_n;
  assign unused_wdata_s = &{1'b0, writedata};

  // Synchronizer chain and one-cycle delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {WIDTH{1'b0}};
      end
      prev_q_r <= {WIDTH{1'b0}};
    end else begin
      sync_r[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_q_r <= sync_q_s;
    end
  end

  // Arm counter: edges are ignored until the chain has flushed its reset contents
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_r <= 3'd0;
    end else if (arm_cnt_r != ARM_MAX) begin
      arm_cnt_r <= arm_cnt_r + 3'd1;
    end else begin
      arm_cnt_r <= arm_cnt_r;
    end
  end

  // Edge selection and capture set/clear terms
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    set_s  = {WIDTH{1'b0}};
    clr_s  = {WIDTH{1'b0}};
    case (EDGE_TYPE)
      32'sd0:  edge_s = sync_q_s & ~prev_q_r;
      32'sd1:  edge_s = ~sync_q_s & prev_q_r;
      32'sd2:  edge_s = sync_q_s ^ prev_q_r;
      default: edge_s = sync_q_s & ~prev_q_r;
    endcase
    if (armed_s) begin
      set_s = edge_s;
    end else begin
      set_s = {WIDTH{1'b0}};
    end
    if (wr_s && (address == 2'd3)) begin
`ifdef PIO_EDGE_BIT_CLEAR_EN
      clr_s = writedata[WIDTH-1:0];
`else
      clr_s = {WIDTH{1'b1}};
`endif
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    // Set is applied after clear so a same-cycle edge survives the clear
    capture_next_s = (capture_r & ~clr_s) | set_s;
  end

  // Capture and mask registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture_r <= {WIDTH{1'b0}};
      mask_r    <= {WIDTH{1'b0}};
    end else begin
      capture_r <= capture_next_s;
      if (wr_s && (address == 2'd2)) begin
        mask_r <= writedata[WIDTH-1:0];
      end else begin
        mask_r <= mask_r;
      end
    end
  end

  // Read mux, zero-extended to the bus width
  always_comb begin
    rdata_s = 32'd0;
    case (address)
      2'd0:    rdata_s[WIDTH-1:0] = sync_q_s;
      2'd2:    rdata_s[WIDTH-1:0] = mask_r;
      2'd3:    rdata_s[WIDTH-1:0] = capture_r;
      default: rdata_s = 32'd0;
    endcase
  end

  // Registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= rdata_s;
    end
  end

  assign irq = |(capture_r & mask_r);

endmodule

// File: doc/pio_edge_capture_in.md
PIO_EDGE_CAPTURE_IN -- requirements
Module: pio_edge_capture_in

Interface
REQ-001 Parameter WIDTH, default 8: number of input bits, 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: capture on rising (0), falling (1), or any (2) edge.
REQ-003 Parameter SYNC_STAGES, default 2: input synchronizer depth, 2..4.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select; qualifies write.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt request.

Function
REQ-013 in_port SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q.
REQ-014 A prev_q register SHALL hold sync_q delayed by one cycle.
REQ-015 Edge per bit: rising = sync_q & ~prev_q; falling = ~sync_q & prev_q; any = sync_q ^ prev_q; selection by EDGE_TYPE.
REQ-016 An arm counter SHALL count from 0 to SYNC_STAGES+1 after reset and then hold; edge detection SHALL be ignored until the count reaches SYNC_STAGES+1, which suppresses spurious edges from the reset state.
REQ-017 Register map: addr 0 = data (RO, sync_q); addr 1 = reserved (reads 0, writes ignored); addr 2 = irq mask (RW, WIDTH bits); addr 3 = edge capture (R, write-to-clear).
REQ-018 readdata SHALL update every clock from the address-selected register, zero-extended to 32 bits (1-cycle read latency, no read strobe).
REQ-019 A write SHALL occur when chipselect=1 and write_n=0 in the same cycle; the register updates on that clock edge.
REQ-020 A detected edge SHALL set its edge-capture bit on the next clock edge; the bit stays set (sticky) until cleared.
REQ-021 If an edge and a clear on the same bit occur in the same cycle, the set SHALL win.
REQ-022 irq SHALL equal OR-reduce(edge_capture & mask), combinational from registers, with no additional latency.
REQ-023 Bits of writedata above WIDTH SHALL be ignored; unused readdata bits SHALL read 0.
REQ-024 Input-to-data latency: a change on in_port SHALL be visible in readdata within SYNC_STAGES+1 clocks.

Reset
REQ-025 While reset_n=0, the synchronizer, prev_q, arm counter, mask, edge capture, and readdata SHALL be 0, and irq SHALL be 0.
REQ-026 A reset asserted mid-operation SHALL clear pending captures immediately and re-arm per REQ-016 after release.

Configuration
REQ-027 Macro PIO_EDGE_BIT_CLEAR_EN selects the clear behaviour.
  - Defined: a write to addr 3 SHALL clear only the bits where writedata=1.
  - Undefined: any write to addr 3 SHALL clear all edge-capture bits, regardless of writedata.

Verification
REQ-028 Reset release with in_port=8'hFF held, EDGE_TYPE=0 -> edge capture stays 8'h00, irq=0; read addr 0 -> 32'h000000FF.
REQ-029 After arming, in_port bit3 goes 0->1, mask=8'h08 -> edge capture=8'h08 within SYNC_STAGES+2 clocks, irq=1; mask=0 -> irq=0 while the capture is still 8'h08.
REQ-030 Captures=8'h0C, write addr 3 data 8'h04 -> 8'h08 with macro defined, 8'h00 with macro undefined.
REQ-031 A rising edge on bit0 in the same cycle as a clear-all write -> bit0 remains 1.
REQ-032 EDGE_TYPE=2, bit1 toggles 1->0->1 with a capture clear in between -> capture set after each toggle.
REQ-033 Write addr 1 data 32'hFFFFFFFF, then read addr 1 -> 0; read addr 2 -> unchanged mask.
